// File: rtl/activation_stream.sv
// activation_stream: two-stage streaming activation unit (ReLU / leaky ReLU /
// clamped ReLU / bypass) over LANES signed 16-bit words per beat.
// Each tensor is framed with out_last, derived from the tensor geometry.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mode                  0=ReLU 1=leaky 2=clamped 3=bypass, latched on first beat
//   in_data/valid/ready   input beat handshake (lane k at bits [16k+15:16k])
//   out_data/valid/ready  output beat handshake, same lane layout
//   out_last              final beat of the tensor
//   busy                  a tensor has been started and its last beat not yet emitted
// Optional (macro ACT_STATS_EN):
//   zero_count            number of zero output words in the last completed tensor
//   stats_valid           one-cycle pulse when zero_count is published
module activation_stream #(
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned X_SIZE       = 1,
  parameter int unsigned Y_SIZE       = 1,
  parameter int unsigned Z_SIZE       = 1,
  parameter int unsigned LANES        = 1,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter logic [15:0] CLAMP_VAL    = 16'h0600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [16*LANES-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [16*LANES-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
`ifdef ACT_STATS_EN
  ,
  output logic [$clog2(NUM_CHANNELS*Z_SIZE*X_SIZE*Y_SIZE+1)-1:0] zero_count,
  output logic                  stats_valid
`endif
);

  localparam int unsigned TOTAL  = NUM_CHANNELS * Z_SIZE * X_SIZE * Y_SIZE;
  localparam int unsigned BEATS  = TOTAL / LANES;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW     = 16 * LANES;
  localparam int unsigned OPEN_W = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    MODE_RELU   = 2'd0,
    MODE_LEAKY  = 2'd1,
    MODE_CLAMP  = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  // Per-lane activation; 16'h8000 falls into the negative branch via bit 15.
  function automatic logic [15:0] activate(input logic [15:0] x, input mode_e m);
    logic [15:0] r;
    r = x;
    unique case (m)
      MODE_RELU:   r = x[15] ? 16'h0000 : x;
      MODE_LEAKY:  r = x[15] ? 16'($signed(x) >>> LEAK_SHIFT) : x;
      MODE_CLAMP:  r = x[15] ? 16'h0000
                             : (($signed(x) > $signed(CLAMP_VAL)) ? CLAMP_VAL : x);
      MODE_BYPASS: r = x;
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mode_e             mode_q, mode_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DW-1:0]     s1_data_q, s1_data_d;
  mode_e             s1_mode_q, s1_mode_d;
  logic              s1_last_q, s1_last_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DW-1:0]     s2_data_q, s2_data_d;
  logic              s2_last_q, s2_last_d;
  logic [OPEN_W-1:0] open_q, open_d;
  logic              busy_q, busy_d;

  logic  s2_load, accept, first_beat, last_beat, out_hs;
  mode_e beat_mode;

  // Handshake and stall control.
  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    in_ready   = !reset && (!s1_valid_q || s2_load);
    accept     = in_valid && in_ready;
    first_beat = (cnt_q == '0);
    last_beat  = (cnt_q == LAST_CNT);
    out_hs     = s2_valid_q && out_ready;
    beat_mode  = first_beat ? mode_e'(mode) : mode_q;
  end

  // Next-state: beat counter, mode latch, both pipeline stages, open-tensor count.
  always_comb begin
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    open_d     = open_q;

    if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
      if (first_beat) mode_d = beat_mode;
    end

    // S1 refills whenever it can hand its beat on (or is empty).
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (accept) begin
        s1_data_d = in_data;
        s1_mode_d = beat_mode;
        s1_last_d = last_beat;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          s2_data_d[16*k +: 16] = activate(s1_data_q[16*k +: 16], s1_mode_q);
        end
      end
    end

    // Tensors can overlap in the pipeline, so busy tracks how many are open.
    open_d = open_q + OPEN_W'(accept && first_beat) - OPEN_W'(out_hs && s2_last_q);
    busy_d = (open_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      mode_q     <= MODE_RELU;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_RELU;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      open_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
      open_q     <= open_d;
      busy_q     <= busy_d;
    end
  end

  assign out_data  = s2_data_q;
  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
  assign busy      = busy_q;

`ifdef ACT_STATS_EN
  localparam int unsigned ZC_W = $clog2(TOTAL + 1);

  logic [ZC_W-1:0] acc_q, acc_d;
  logic [ZC_W-1:0] zc_q, zc_d;
  logic            sv_q, sv_d;
  logic [ZC_W-1:0] beat_zeros;
  logic [ZC_W-1:0] acc_sum;

  // Zero-word accumulation on accepted output beats; published after the last one.
  always_comb begin
    acc_d      = acc_q;
    zc_d       = zc_q;
    sv_d       = 1'b0;
    beat_zeros = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      beat_zeros = beat_zeros + ((s2_data_q[16*k +: 16] == 16'h0000) ? ZC_W'(1) : ZC_W'(0));
    end
    acc_sum = acc_q + beat_zeros;
    if (out_hs) begin
      if (s2_last_q) begin
        zc_d  = acc_sum;
        sv_d  = 1'b1;
        acc_d = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      zc_q  <= '0;
      sv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      zc_q  <= zc_d;
      sv_q  <= sv_d;
    end
  end

  assign zero_count  = zc_q;
  assign stats_valid = sv_q;
`endif

endmodule
